// File: rtl/wb_retire_unit.sv
// Writeback/retire stage: registers the M-stage instruction and produces the
// register-file write port (with load extraction) and a retired-instruction count.
module wb_retire_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stallW,
   input  logic             flushW,
   input  logic             validM,
   input  logic             reg_wrM,
   input  logic [4:0]       rd_addrM,
   input  logic [1:0]       sel_ldM,
   input  logic [2:0]       funct3M,
   input  logic [XLEN-1:0]  resultM,
   input  logic [XLEN-1:0]  dm_rdM,
   input  logic [XLEN-1:0]  PCp4M,
   output logic             rf_weW,
   output logic [4:0]       rf_waW,
   output logic [XLEN-1:0]  rf_wdW,
   output logic             validW,
   output logic [CNT_W-1:0] instret
);

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [1:0] SEL_PC4  = 2'b01;
   localparam logic [1:0] SEL_LOAD = 2'b10;

   logic             r_valid;
   logic             r_regWr;
   logic [4:0]       r_rdAddr;
   logic [1:0]       r_selLd;
   logic [2:0]       r_funct3;
   logic [1:0]       r_lsb;
   logic [XLEN-1:0]  r_result;
   logic [XLEN-1:0]  r_dmRd;
   logic [XLEN-1:0]  r_pcp4;
   logic [CNT_W-1:0] r_instret;

   logic [7:0]       w_byte;
   logic [15:0]      w_half;
   logic [XLEN-1:0]  w_loadData;

   // Flush only needs to kill valid and the write request; stall freezes everything,
   // including the retire counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid   <= 1'b0;
         r_regWr   <= 1'b0;
         r_rdAddr  <= '0;
         r_selLd   <= '0;
         r_funct3  <= '0;
         r_lsb     <= '0;
         r_result  <= '0;
         r_dmRd    <= '0;
         r_pcp4    <= '0;
         r_instret <= '0;
      end else if (flushW) begin
         r_valid <= 1'b0;
         r_regWr <= 1'b0;
      end else if (!stallW) begin
         r_valid  <= validM;
         r_regWr  <= reg_wrM;
         r_rdAddr <= rd_addrM;
         r_selLd  <= sel_ldM;
         r_funct3 <= funct3M;
         r_lsb    <= resultM[1:0];
         r_result <= resultM;
         r_dmRd   <= dm_rdM;
         r_pcp4   <= PCp4M;
         if (validM) begin
            r_instret <= r_instret + CNT_W'(1);
         end
      end
   end

   // Misaligned halves are not trapped here: lsb[0] is simply ignored.
   always_comb begin
      w_byte = r_dmRd[7:0];
      case (r_lsb)
         2'd1:    w_byte = r_dmRd[15:8];
         2'd2:    w_byte = r_dmRd[23:16];
         2'd3:    w_byte = r_dmRd[31:24];
         default: w_byte = r_dmRd[7:0];
      endcase
      w_half = r_lsb[1] ? r_dmRd[31:16] : r_dmRd[15:0];
   end

   always_comb begin
      w_loadData = r_dmRd;
      case (r_funct3)
         F3_LB:   w_loadData = {{(XLEN-8){w_byte[7]}}, w_byte};
         F3_LBU:  w_loadData = {{(XLEN-8){1'b0}}, w_byte};
         F3_LH:   w_loadData = {{(XLEN-16){w_half[15]}}, w_half};
         F3_LHU:  w_loadData = {{(XLEN-16){1'b0}}, w_half};
         default: w_loadData = r_dmRd;
      endcase
   end

   always_comb begin
      rf_wdW = r_result;
      case (r_selLd)
         SEL_PC4:  rf_wdW = r_pcp4;
         SEL_LOAD: rf_wdW = w_loadData;
         default:  rf_wdW = r_result;
      endcase
   end

   // x0 is hardwired to zero, so writes to it never reach the register file.
   assign rf_weW  = r_valid & r_regWr & (r_rdAddr != 5'd0);
   assign rf_waW  = r_rdAddr;
   assign validW  = r_valid;
   assign instret = r_instret;

endmodule

// File: tb/tb_wb_retire_unit.sv
// Directed bench for wb_retire_unit: load extraction, source selects, stall/flush,
// reset behaviour and counter wrap (a second instance with a 4-bit counter).
module tb_wb_retire_unit;

   logic        clk = 1'b0;
   logic        rst, stallW, flushW, validM, reg_wrM;
   logic [4:0]  rd_addrM;
   logic [1:0]  sel_ldM;
   logic [2:0]  funct3M;
   logic [31:0] resultM, dm_rdM, PCp4M;

   logic        rf_weW, validW;
   logic [4:0]  rf_waW;
   logic [31:0] rf_wdW;
   logic [63:0] instret;

   logic        w4_rfWe, w4_valid;
   logic [4:0]  w4_rfWa;
   logic [31:0] w4_rfWd;
   logic [3:0]  w4_instret;

   int          passCnt = 0;
   int          totalCnt = 0;
   logic [63:0] expCnt = '0;
   logic [3:0]  expCnt4 = '0;

   always #5 clk = ~clk;

   wb_retire_unit #(.XLEN(32), .CNT_W(64)) dut (
      .clk(clk), .rst(rst), .stallW(stallW), .flushW(flushW), .validM(validM),
      .reg_wrM(reg_wrM), .rd_addrM(rd_addrM), .sel_ldM(sel_ldM), .funct3M(funct3M),
      .resultM(resultM), .dm_rdM(dm_rdM), .PCp4M(PCp4M),
      .rf_weW(rf_weW), .rf_waW(rf_waW), .rf_wdW(rf_wdW), .validW(validW), .instret(instret)
   );

   wb_retire_unit #(.XLEN(32), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .stallW(stallW), .flushW(flushW), .validM(validM),
      .reg_wrM(reg_wrM), .rd_addrM(rd_addrM), .sel_ldM(sel_ldM), .funct3M(funct3M),
      .resultM(resultM), .dm_rdM(dm_rdM), .PCp4M(PCp4M),
      .rf_weW(w4_rfWe), .rf_waW(w4_rfWa), .rf_wdW(w4_rfWd), .validW(w4_valid), .instret(w4_instret)
   );

   task automatic setM(input logic v, input logic wr, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [31:0] res, input logic [31:0] dm,
                       input logic [31:0] pc4);
      validM = v; reg_wrM = wr; rd_addrM = rd; sel_ldM = sel; funct3M = f3;
      resultM = res; dm_rdM = dm; PCp4M = pc4;
   endtask

   // Advance one edge; the reference counters follow the retire rule independently.
   task automatic tick();
      if (rst) begin
         expCnt = '0; expCnt4 = '0;
      end else if (!flushW && !stallW && validM) begin
         expCnt = expCnt + 64'd1; expCnt4 = expCnt4 + 4'd1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; stallW = 1'b0; flushW = 1'b0;
      setM(1'b1, 1'b1, 5'd9, 2'b10, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8);
      tick(); tick();
      totalCnt++; if (validW !== 1'b0) $display("[TB] FAIL reset_valid got %b want 0", validW); else passCnt++;
      totalCnt++; if (rf_weW !== 1'b0) $display("[TB] FAIL reset_we got %b want 0", rf_weW); else passCnt++;
      totalCnt++; if (rf_waW !== 5'd0) $display("[TB] FAIL reset_wa got %0d want 0", rf_waW); else passCnt++;
      totalCnt++; if (rf_wdW !== 32'h0) $display("[TB] FAIL reset_wd got %h want 0", rf_wdW); else passCnt++;
      totalCnt++; if (instret !== 64'd0) $display("[TB] FAIL reset_instret got %0d want 0", instret); else passCnt++;
      totalCnt++; if (w4_instret !== 4'd0) $display("[TB] FAIL reset_instret4 got %0d want 0", w4_instret); else passCnt++;
      rst = 1'b0;
   endtask

   task automatic test_loads();
      setM(1'b1, 1'b1, 5'd5, 2'b10, 3'b000, 32'h0000_1003, 32'h80FF_0000, 32'h0);
      tick();
      totalCnt++; if (rf_wdW !== 32'hFFFF_FF80) $display("[TB] FAIL lb_sign wd got %h want ffffff80", rf_wdW); else passCnt++;
      totalCnt++; if (rf_weW !== 1'b1) $display("[TB] FAIL lb_sign we got %b want 1", rf_weW); else passCnt++;
      totalCnt++; if (rf_waW !== 5'd5) $display("[TB] FAIL lb_sign wa got %0d want 5", rf_waW); else passCnt++;
      totalCnt++; if (validW !== 1'b1) $display("[TB] FAIL lb_sign valid got %b want 1", validW); else passCnt++;
      setM(1'b1, 1'b1, 5'd6, 2'b10, 3'b100, 32'h0000_0001, 32'h1234_F678, 32'h0);
      tick();
      totalCnt++; if (rf_wdW !== 32'h0000_00F6) $display("[TB] FAIL lbu_a1 got %h want 000000f6", rf_wdW); else passCnt++;
      setM(1'b1, 1'b1, 5'd6, 2'b10, 3'b101, 32'h0000_0002, 32'h1234_F678, 32'h0);
      tick();
      totalCnt++; if (rf_wdW !== 32'h0000_1234) $display("[TB] FAIL lhu_a2 got %h want 00001234", rf_wdW); else passCnt++;
      setM(1'b1, 1'b1, 5'd6, 2'b10, 3'b001, 32'h0000_0000, 32'h1234_F678, 32'h0);
      tick();
      totalCnt++; if (rf_wdW !== 32'hFFFF_F678) $display("[TB] FAIL lh_a0 got %h want fffff678", rf_wdW); else passCnt++;
      setM(1'b1, 1'b1, 5'd6, 2'b10, 3'b000, 32'h0000_0000, 32'h1234_F678, 32'h0);
      tick();
      totalCnt++; if (rf_wdW !== 32'h0000_0078) $display("[TB] FAIL lb_a0 got %h want 00000078", rf_wdW); else passCnt++;
      setM(1'b1, 1'b1, 5'd6, 2'b10, 3'b001, 32'h0000_0003, 32'h8765_0000, 32'h0);
      tick();
      totalCnt++; if (rf_wdW !== 32'hFFFF_8765) $display("[TB] FAIL lh_a3 got %h want ffff8765", rf_wdW); else passCnt++;
      setM(1'b1, 1'b1, 5'd6, 2'b10, 3'b010, 32'h0000_0002, 32'h1234_F678, 32'h0);
      tick();
      totalCnt++; if (rf_wdW !== 32'h1234_F678) $display("[TB] FAIL lw got %h want 1234f678", rf_wdW); else passCnt++;
      setM(1'b1, 1'b1, 5'd6, 2'b10, 3'b111, 32'h0000_0001, 32'hCAFE_0011, 32'h0);
      tick();
      totalCnt++; if (rf_wdW !== 32'hCAFE_0011) $display("[TB] FAIL f3_other got %h want cafe0011", rf_wdW); else passCnt++;
   endtask

   task automatic test_sources();
      setM(1'b1, 1'b1, 5'd1, 2'b01, 3'b000, 32'h0000_0FFF, 32'hFFFF_FFFF, 32'h0000_0104);
      tick();
      totalCnt++; if (rf_wdW !== 32'h0000_0104) $display("[TB] FAIL sel_pc4 got %h want 00000104", rf_wdW); else passCnt++;
      setM(1'b1, 1'b1, 5'd2, 2'b11, 3'b000, 32'hDEAD_BEEF, 32'h1111_1111, 32'h4);
      tick();
      totalCnt++; if (rf_wdW !== 32'hDEAD_BEEF) $display("[TB] FAIL sel_11 got %h want deadbeef", rf_wdW); else passCnt++;
      setM(1'b1, 1'b1, 5'd3, 2'b00, 3'b000, 32'h0000_0055, 32'h1111_1111, 32'h4);
      tick();
      totalCnt++; if (rf_wdW !== 32'h0000_0055) $display("[TB] FAIL sel_00 got %h want 00000055", rf_wdW); else passCnt++;
      setM(1'b1, 1'b1, 5'd0, 2'b00, 3'b000, 32'h0000_0077, 32'h0, 32'h4);
      tick();
      totalCnt++; if (rf_weW !== 1'b0) $display("[TB] FAIL x0_suppress we got %b want 0", rf_weW); else passCnt++;
      totalCnt++; if (validW !== 1'b1) $display("[TB] FAIL x0_valid got %b want 1", validW); else passCnt++;
      setM(1'b1, 1'b0, 5'd3, 2'b00, 3'b000, 32'h0000_0077, 32'h0, 32'h4);
      tick();
      totalCnt++; if (rf_weW !== 1'b0) $display("[TB] FAIL nowr we got %b want 0", rf_weW); else passCnt++;
      setM(1'b0, 1'b1, 5'd3, 2'b00, 3'b000, 32'h0000_0077, 32'h0, 32'h4);
      tick();
      totalCnt++; if (rf_weW !== 1'b0) $display("[TB] FAIL bubble we got %b want 0", rf_weW); else passCnt++;
      totalCnt++; if (validW !== 1'b0) $display("[TB] FAIL bubble valid got %b want 0", validW); else passCnt++;
      totalCnt++; if (instret !== expCnt) $display("[TB] FAIL count_after_bubble got %0d want %0d", instret, expCnt); else passCnt++;
   endtask

   task automatic test_stall_flush();
      logic [63:0] heldCnt;
      setM(1'b1, 1'b1, 5'd7, 2'b00, 3'b000, 32'h0000_A5A5, 32'h0, 32'h4);
      tick();
      heldCnt = expCnt;
      stallW = 1'b1;
      for (int i = 0; i < 3; i++) begin
         setM(1'b1, 1'b1, 5'(10 + i), 2'b01, 3'b000, 32'h0BAD_0000 + 32'(i), 32'h0, 32'h0000_0200);
         tick();
         totalCnt++; if (rf_waW !== 5'd7) $display("[TB] FAIL stall_wa%0d got %0d want 7", i, rf_waW); else passCnt++;
         totalCnt++; if (rf_wdW !== 32'h0000_A5A5) $display("[TB] FAIL stall_wd%0d got %h want 0000a5a5", i, rf_wdW); else passCnt++;
         totalCnt++; if (rf_weW !== 1'b1) $display("[TB] FAIL stall_we%0d got %b want 1", i, rf_weW); else passCnt++;
         totalCnt++; if (instret !== heldCnt) $display("[TB] FAIL stall_cnt%0d got %0d want %0d", i, instret, heldCnt); else passCnt++;
      end
      stallW = 1'b0;
      tick();
      totalCnt++; if (rf_waW !== 5'd12) $display("[TB] FAIL unstall_wa got %0d want 12", rf_waW); else passCnt++;
      totalCnt++; if (rf_wdW !== 32'h0000_0200) $display("[TB] FAIL unstall_wd got %h want 00000200", rf_wdW); else passCnt++;
      totalCnt++; if (instret !== heldCnt + 64'd1) $display("[TB] FAIL unstall_cnt got %0d want %0d", instret, heldCnt + 64'd1); else passCnt++;
      heldCnt = expCnt;
      stallW = 1'b1; flushW = 1'b1;
      tick();
      totalCnt++; if (validW !== 1'b0) $display("[TB] FAIL flush_stall valid got %b want 0", validW); else passCnt++;
      totalCnt++; if (rf_weW !== 1'b0) $display("[TB] FAIL flush_stall we got %b want 0", rf_weW); else passCnt++;
      totalCnt++; if (instret !== heldCnt) $display("[TB] FAIL flush_cnt got %0d want %0d", instret, heldCnt); else passCnt++;
      stallW = 1'b0; flushW = 1'b0;
   endtask

   task automatic test_reset_mid_stall();
      setM(1'b1, 1'b1, 5'd9, 2'b11, 3'b000, 32'h1357_9BDF, 32'h0, 32'h4);
      tick();
      stallW = 1'b1; rst = 1'b1;
      tick();
      totalCnt++; if (validW !== 1'b0) $display("[TB] FAIL rst_stall valid got %b want 0", validW); else passCnt++;
      totalCnt++; if (rf_wdW !== 32'h0) $display("[TB] FAIL rst_stall wd got %h want 0", rf_wdW); else passCnt++;
      totalCnt++; if (instret !== 64'd0) $display("[TB] FAIL rst_stall cnt got %0d want 0", instret); else passCnt++;
      stallW = 1'b0; rst = 1'b0;
      setM(1'b1, 1'b1, 5'd4, 2'b00, 3'b000, 32'h0000_0042, 32'h0, 32'h4);
      tick();
      totalCnt++; if (rf_wdW !== 32'h0000_0042 || rf_waW !== 5'd4) $display("[TB] FAIL first_capture got wa=%0d wd=%h want wa=4 wd=00000042", rf_waW, rf_wdW); else passCnt++;
      totalCnt++; if (instret !== 64'd1) $display("[TB] FAIL first_capture cnt got %0d want 1", instret); else passCnt++;
   endtask

   task automatic test_wrap();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 17; i++) begin
         setM(1'b1, 1'b1, 5'd8, 2'b00, 3'b000, 32'(i), 32'h0, 32'h4);
         tick();
      end
      totalCnt++; if (w4_instret !== 4'd1) $display("[TB] FAIL wrap4 got %0d want 1", w4_instret); else passCnt++;
      totalCnt++; if (instret !== 64'd17) $display("[TB] FAIL wrap64 got %0d want 17", instret); else passCnt++;
      totalCnt++; if (w4_instret !== expCnt4) $display("[TB] FAIL wrap_model got %0d want %0d", w4_instret, expCnt4); else passCnt++;
      tick(); tick();
      rst = 1'b1;
      tick();
      totalCnt++; if (w4_instret !== 4'd0) $display("[TB] FAIL midrst cnt4 got %0d want 0", w4_instret); else passCnt++;
      totalCnt++; if (w4_valid !== 1'b0) $display("[TB] FAIL midrst valid got %b want 0", w4_valid); else passCnt++;
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_loads();
      test_sources();
      test_stall_flush();
      test_reset_mid_stall();
      test_wrap();
      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
